// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbitration for the shared 8:1 4-bit mux channel.
// Grants are held up to HOLD_MAX cycles, then rotate with no idle gap.
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       enable,
  output logic       rel
);

  typedef enum logic {
    IDLE,
    GRANT
  } st_t;

  localparam logic [3:0] HMAX = 4'(HOLD_MAX);

  st_t        st, st_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] cur, cur_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] grant_n;
  logic [2:0] sel, sel_n;
  logic       en_n;
  logic       rel_n;
  logic       rls;

  function automatic logic [2:0] pick(
    input logic [2:0] p,
    input logic [7:0] r
  );
    logic [2:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign rls = !req[cur] || (cnt == HMAX);

  // state and registered mux controls
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      ptr    <= '0;
      cur    <= '0;
      cnt    <= '0;
      grant  <= '0;
      sel    <= '0;
      enable <= 1'b0;
      rel    <= 1'b0;
    end else begin
      st     <= st_n;
      ptr    <= ptr_n;
      cur    <= cur_n;
      cnt    <= cnt_n;
      grant  <= grant_n;
      sel    <= sel_n;
      enable <= en_n;
      rel    <= rel_n;
    end
  end

  // next owner selection, hold counting and release pulse
  always_comb begin
    st_n    = st;
    ptr_n   = ptr;
    cur_n   = cur;
    cnt_n   = cnt;
    grant_n = grant;
    sel_n   = sel;
    en_n    = enable;
    rel_n   = 1'b0;
    unique case (st)
      IDLE: begin
        grant_n = '0;
        sel_n   = '0;
        en_n    = 1'b0;
        if (req != 8'h00) begin
          cur_n   = pick(ptr, req);
          cnt_n   = 4'd1;
          st_n    = GRANT;
          grant_n = 8'h01 << cur_n;
          sel_n   = cur_n;
          en_n    = 1'b1;
        end
      end
      GRANT: begin
        if (!rls) begin
          cnt_n = cnt + 4'd1;
        end else begin
          ptr_n = cur + 3'd1;
          rel_n = 1'b1;
          if (req != 8'h00) begin
            cur_n   = pick(cur + 3'd1, req);
            cnt_n   = 4'd1;
            grant_n = 8'h01 << cur_n;
            sel_n   = cur_n;
            en_n    = 1'b1;
          end else begin
            st_n    = IDLE;
            cnt_n   = '0;
            grant_n = '0;
            sel_n   = '0;
            en_n    = 1'b0;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign sel0 = sel[0];
  assign sel1 = sel[1];
  assign sel2 = sel[2];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter.
// Second instance runs with HOLD_MAX=1.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant, grant1;
  logic       sel0, sel1, sel2, enable, rel;
  logic       s10, s11, s12, en1, rel1;
  logic [12:0] obs, obs1, e;
  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant), .sel0(sel0), .sel1(sel1),
    .sel2(sel2), .enable(enable), .rel(rel)
  );

  mux8_rr_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant1), .sel0(s10), .sel1(s11),
    .sel2(s12), .enable(en1), .rel(rel1)
  );

  assign obs  = {grant, sel2, sel1, sel0, enable, rel};
  assign obs1 = {grant1, s12, s11, s10, en1, rel1};

  function automatic logic [12:0] ex(
    input logic [7:0] g, input logic [2:0] s,
    input logic en, input logic r
  );
    return {g, s, en, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF;
    tick(); tick();
    e = ex(8'h00, 3'd0, 1'b0, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL reset: got %h want %h", obs, e);
    end
    rst = 1'b0;
    tick();
    e = ex(8'h01, 3'd0, 1'b1, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL first_grant: got %h want %h", obs, e);
    end
  endtask

  task automatic test_full_rotation();
    logic [2:0] o3;
    for (int o = 0; o <= 8; o++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(o == 8 && c > 0)) begin
          if (!(o == 0 && c == 0)) tick();
          o3 = 3'(o);
          e = ex(8'h01 << o3, o3, 1'b1, (c == 0 && o > 0));
          nchk++;
          if (obs !== e) begin
            nfail++;
            $display("FAIL rotate o=%0d c=%0d: got %h want %h",
                     o, c, obs, e);
          end
        end
      end
    end
    req = 8'h00;
    tick();
    e = ex(8'h00, 3'd0, 1'b0, 1'b1);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL rotate_idle: got %h want %h", obs, e);
    end
    tick();
    e = ex(8'h00, 3'd0, 1'b0, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL rotate_rel_off: got %h want %h", obs, e);
    end
  endtask

  task automatic test_single_holder();
    req = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick();
      e = ex(8'h08, 3'd3, 1'b1, 1'b0);
      nchk++;
      if (obs !== e) begin
        nfail++;
        $display("FAIL hold c=%0d: got %h want %h", c, obs, e);
      end
    end
    tick();
    e = ex(8'h08, 3'd3, 1'b1, 1'b1);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL regrant: got %h want %h", obs, e);
    end
    tick();
    e = ex(8'h08, 3'd3, 1'b1, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL regrant_next: got %h want %h", obs, e);
    end
    req = 8'h00;
    tick();
    e = ex(8'h00, 3'd0, 1'b0, 1'b1);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL hold_drop: got %h want %h", obs, e);
    end
  endtask

  task automatic test_early_drop();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h44;
    tick();
    e = ex(8'h04, 3'd2, 1'b1, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL drop_own2: got %h want %h", obs, e);
    end
    tick();
    req = 8'h40;
    tick();
    e = ex(8'h40, 3'd6, 1'b1, 1'b1);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL drop_hand6: got %h want %h", obs, e);
    end
  endtask

  task automatic test_wrap();
    req = 8'h80;
    tick();
    e = ex(8'h80, 3'd7, 1'b1, 1'b1);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL wrap_own7: got %h want %h", obs, e);
    end
    req = 8'h81;
    for (int c = 0; c < 3; c++) begin
      tick();
      e = ex(8'h80, 3'd7, 1'b1, 1'b0);
      nchk++;
      if (obs !== e) begin
        nfail++;
        $display("FAIL wrap_hold c=%0d: got %h want %h", c, obs, e);
      end
    end
    tick();
    e = ex(8'h01, 3'd0, 1'b1, 1'b1);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL wrap_to0: got %h want %h", obs, e);
    end
    req = 8'h00;
    tick();
    e = ex(8'h00, 3'd0, 1'b0, 1'b1);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL wrap_idle: got %h want %h", obs, e);
    end
  endtask

  task automatic test_reset_mid();
    req = 8'h20;
    tick(); tick();
    e = ex(8'h20, 3'd5, 1'b1, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL mid_own5: got %h want %h", obs, e);
    end
    rst = 1'b1; req = 8'h60;
    tick();
    e = ex(8'h00, 3'd0, 1'b0, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL mid_reset: got %h want %h", obs, e);
    end
    rst = 1'b0;
    tick();
    e = ex(8'h20, 3'd5, 1'b1, 1'b0);
    nchk++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL mid_after: got %h want %h", obs, e);
    end
  endtask

  task automatic test_hold1();
    logic [2:0] o3;
    rst = 1'b1; req = 8'hFF;
    tick(); rst = 1'b0;
    for (int o = 0; o < 10; o++) begin
      tick();
      o3 = 3'(o);
      e = ex(8'h01 << o3, o3, 1'b1, (o > 0));
      nchk++;
      if (obs1 !== e) begin
        nfail++;
        $display("FAIL hold1 o=%0d: got %h want %h", o, obs1, e);
      end
    end
    req = 8'h00;
    tick();
    e = ex(8'h00, 3'd0, 1'b0, 1'b1);
    nchk++;
    if (obs1 !== e) begin
      nfail++;
      $display("FAIL hold1_idle: got %h want %h", obs1, e);
    end
  endtask

  initial begin
    test_reset();
    test_full_rotation();
    test_single_holder();
    test_early_drop();
    test_wrap();
    test_reset_mid();
    test_hold1();
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares the 8:1 4-bit mux (`mux_8x1_4bit`) output channel between eight requesters. Requester i drives mux data input i (a = 0 … h = 7). This block decides which requester owns the channel and drives the mux `sel2`/`sel1`/`sel0` and `enable` pins directly from registers. A granted requester keeps the channel until it drops its request or until `HOLD_MAX` cycles have elapsed. Ownership then rotates with no idle bubble.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles one grant is held. Legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  8  request per channel; bit i = mux input i.
- `grant`  out  8  one-hot owner of the mux; 0 when idle. Registered.
- `sel0`, `sel1`, `sel2`  out  1 each  binary index of the granted bit, {sel2,sel1,sel0}. Registered.
- `enable`  out  1  mux enable; 1 whenever `grant` != 0. Registered.
- `rel`  out  1  one-cycle pulse; asserted in the cycle after any grant terminates. Registered.

## Operation
- Internal state:
  - `st`: IDLE or GRANT.
  - `ptr` (3 bits): search start point.
  - `cur` (3 bits): index of the current owner.
  - `cnt` (4 bits): cycles the current grant has been held.
- Pick function `pick(p, r)`: the first set bit of r, scanning indices p, p+1, … modulo 8.
- IDLE:
  - If req == 0: stay in IDLE; grant=0, enable=0, rel=0.
  - If req != 0: set cur = pick(ptr, req); go to GRANT with cnt=1, grant=one-hot(cur), {sel2,sel1,sel0}=cur, enable=1.
- GRANT, evaluated each edge:
  - Release condition: req[cur]==0 OR cnt==HOLD_MAX.
  - No release: cnt = cnt+1; all outputs hold.
  - On release: ptr = cur+1 (mod 8, so 7 wraps to 0); rel=1 for the next cycle.
  - Release with req != 0: cur = pick(cur+1, req); cnt=1; stay in GRANT. This is a direct handoff; enable stays 1 with no gap.
  - If only the current owner is still requesting at HOLD_MAX, the pick wraps back to cur. The same owner is re-granted: grant unchanged, cnt=1, rel still pulses.
  - Release with req == 0: go to IDLE; grant=0, sel=0, enable=0.
- Arithmetic:
  - ptr and cur are modulo 8.
  - cnt never exceeds HOLD_MAX.
  - With HOLD_MAX=1, every grant lasts exactly one cycle.
- `grant` is always zero or exactly one-hot. `sel` always encodes the `grant` bit; sel=0 when idle.
- Requests are level-sensitive. The block applies no fairness memory beyond `ptr`.

## Timing
- Reset values (next edge with rst=1, regardless of req): st=IDLE, ptr=0, cur=0, cnt=0, grant=0, sel=0, enable=0, rel=0.
- rst overrides everything, including a grant in progress. The first grant after reset starts its search from index 0.
- Latency from IDLE: req sampled at edge k → grant/sel/enable valid after edge k (1-cycle latency).
- Handoff: the release edge and the new-grant edge are the same edge. New outputs appear in the cycle after the last owned cycle.
- Grant duration: an owner whose request stays high sees grant for exactly HOLD_MAX cycles. A drop seen at edge k ends ownership after edge k, so the owner keeps grant for one cycle after deasserting req.
- rel is high for exactly one cycle per termination, including re-grant to the same owner. It is never high in back-to-back cycles unless HOLD_MAX=1 or successive drops occur.
- req changes only affect the pick at the edges where a pick is made (IDLE, or a release edge).

## Test plan
- Reset: rst=1 for 2 cycles with req=8'hFF → grant=0, sel=0, enable=0, rel=0. Release rst → next edge grant=8'h01, sel=0, enable=1.
- Single holder (HOLD_MAX=4): req=8'h08 held from IDLE → grant=8'h08, sel=3 for 4 cycles. rel pulses, then grant=8'h08 again with enable staying 1 throughout.
- Full rotation: req=8'hFF, HOLD_MAX=4 → grant 0,1,2,…,7,0, each for 4 cycles. sel tracks 0…7; rel pulses at each handoff; enable never drops.
- Early drop: owner 2; req=8'h44; after 2 cycles req=8'h40 → next edge grant=8'h40, sel=6, rel=1.
- Wrap priority: after owner 7 releases at HOLD_MAX with req=8'h81 → grant=8'h01 (index 0 beats 7). Then req=8'h00 at release → IDLE, enable=0, rel=1.
- Reset mid-grant: owner 5 at cnt=2; pulse rst one cycle with req=8'h60 → outputs reset. Next edge grant=8'h20, sel=5 (search from ptr=0 finds 5 before 6).
